// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: ALU function codes, control-bit positions and stage FSM states.
package cpu_pipe_pkg;

  localparam int unsigned CtrlW    = 4;
  localparam int unsigned AluOpW   = 6;
  localparam int unsigned RegAddrW = 5;

  // Bit positions inside ctrl = {regShouldWrite, isRtype, memRead, memWrite}
  localparam int unsigned CtrlRegWrite = 3;
  localparam int unsigned CtrlIsRtype  = 2;
  localparam int unsigned CtrlMemRead  = 1;
  localparam int unsigned CtrlMemWrite = 0;

  localparam logic [AluOpW-1:0] AluSll = 6'b000000;
  localparam logic [AluOpW-1:0] AluSrl = 6'b000010;
  localparam logic [AluOpW-1:0] AluSra = 6'b000011;
  localparam logic [AluOpW-1:0] AluAdd = 6'b100000;
  localparam logic [AluOpW-1:0] AluSub = 6'b100010;
  localparam logic [AluOpW-1:0] AluAnd = 6'b100100;
  localparam logic [AluOpW-1:0] AluOr  = 6'b100101;
  localparam logic [AluOpW-1:0] AluXor = 6'b100110;
  localparam logic [AluOpW-1:0] AluSlt = 6'b101010;

  // A bubble carries SLL with all-zero operands, i.e. a true no-op.
  localparam logic [AluOpW-1:0] NOP_OPCODE = AluSll;

  typedef enum logic [1:0] {
    StEmpty  = 2'b00,
    StRun    = 2'b01,
    StBubble = 2'b10
  } pipe_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EXE whose destination is read by the instruction in ID.
module load_use_detect
  import cpu_pipe_pkg::*;
(
  input  logic                exe_valid_i,
  input  logic [CtrlW-1:0]    exe_ctrl_i,
  input  logic [RegAddrW-1:0] exe_dest_i,
  input  logic                id_valid_i,
  input  logic [CtrlW-1:0]    id_ctrl_i,
  input  logic [RegAddrW-1:0] id_rs_i,
  input  logic [RegAddrW-1:0] id_rt_i,
  output logic                hazard_o
);

  logic exe_is_load;
  logic rt_is_read;

  always_comb begin
    exe_is_load = exe_valid_i & exe_ctrl_i[CtrlMemRead] & exe_ctrl_i[CtrlRegWrite] &
                  (exe_dest_i != '0);
    // rt is a source only for R-type ops and for the store data of sw
    rt_is_read  = id_ctrl_i[CtrlIsRtype] | id_ctrl_i[CtrlMemWrite];
    hazard_o    = exe_is_load & id_valid_i &
                  ((exe_dest_i == id_rs_i) | (rt_is_read & (exe_dest_i == id_rt_i)));
  end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with load-use stall, flush and hold handling.
// Optional bubble counter enabled by defining ID_EXE_PERF_COUNT_EN.
module id_exe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                valid_ID,
  input  logic [RegAddrW-1:0] regReadAddress1_ID,
  input  logic [RegAddrW-1:0] regReadAddress2_ID,
  input  logic [N-1:0]        regReadData1_ID,
  input  logic [N-1:0]        operandB_ID,
  input  logic [RegAddrW-1:0] regWriteAddress_ID,
  input  logic [CtrlW-1:0]    ctrl_ID,
  input  logic [AluOpW-1:0]   aluOpCode_ID,
  input  logic                flush,
  input  logic                hold,
  output logic                valid_IDtoEXE,
  output logic [RegAddrW-1:0] regReadAddress1_IDtoEXE,
  output logic [RegAddrW-1:0] regReadAddress2_IDtoEXE,
  output logic [N-1:0]        inputA_reg,
  output logic [N-1:0]        inputB_IDtoEXE,
  output logic [RegAddrW-1:0] regWriteAddress_IDtoEXE,
  output logic [CtrlW-1:0]    ctrl_IDtoEXE,
  output logic [AluOpW-1:0]   aluOpCode_IDtoEXE,
  output logic                stall,
  output logic [31:0]         bubbleCount
);

  pipe_state_e state_q, state_d;
  logic hazard;
  logic stall_raw;
  logic load_bubble;
  logic load_instr;
  logic count_inc;

  load_use_detect u_load_use_detect (
    .exe_valid_i (valid_IDtoEXE),
    .exe_ctrl_i  (ctrl_IDtoEXE),
    .exe_dest_i  (regWriteAddress_IDtoEXE),
    .id_valid_i  (valid_ID),
    .id_ctrl_i   (ctrl_ID),
    .id_rs_i     (regReadAddress1_ID),
    .id_rt_i     (regReadAddress2_ID),
    .hazard_o    (hazard)
  );

  always_comb begin
    stall_raw   = 1'b0;
    load_bubble = 1'b0;
    load_instr  = 1'b0;
    count_inc   = 1'b0;
    state_d     = state_q;
    if (flush) begin
      load_bubble = 1'b1;
      count_inc   = 1'b1;
      state_d     = StEmpty;
    end else if (hold) begin
      stall_raw = 1'b1;
    end else if (hazard) begin
      stall_raw   = 1'b1;
      load_bubble = 1'b1;
      count_inc   = 1'b1;
      state_d     = StBubble;
    end else begin
      load_instr = 1'b1;
      unique case (state_q)
        StEmpty:  state_d = valid_ID ? StRun : StEmpty;
        StRun:    state_d = StRun;
        StBubble: state_d = StRun;
        default:  state_d = StEmpty;
      endcase
    end
  end

  // Reset clears the stall combinationally so IF/ID is released in the same cycle.
  assign stall = stall_raw & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_IDtoEXE           <= 1'b0;
      regReadAddress1_IDtoEXE <= '0;
      regReadAddress2_IDtoEXE <= '0;
      inputA_reg              <= '0;
      inputB_IDtoEXE          <= '0;
      regWriteAddress_IDtoEXE <= '0;
      ctrl_IDtoEXE            <= '0;
      aluOpCode_IDtoEXE       <= NOP_OPCODE;
    end else if (load_bubble) begin
      valid_IDtoEXE           <= 1'b0;
      regReadAddress1_IDtoEXE <= '0;
      regReadAddress2_IDtoEXE <= '0;
      inputA_reg              <= '0;
      inputB_IDtoEXE          <= '0;
      regWriteAddress_IDtoEXE <= '0;
      ctrl_IDtoEXE            <= '0;
      aluOpCode_IDtoEXE       <= NOP_OPCODE;
    end else if (load_instr) begin
      valid_IDtoEXE           <= valid_ID;
      regReadAddress1_IDtoEXE <= regReadAddress1_ID;
      regReadAddress2_IDtoEXE <= regReadAddress2_ID;
      inputA_reg              <= regReadData1_ID;
      inputB_IDtoEXE          <= operandB_ID;
      regWriteAddress_IDtoEXE <= regWriteAddress_ID;
      ctrl_IDtoEXE            <= ctrl_ID;
      aluOpCode_IDtoEXE       <= aluOpCode_ID;
    end
  end

`ifdef ID_EXE_PERF_COUNT_EN
  logic [31:0] bubble_cnt_q;

  // Free-running wrap at 2^32 is intended.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_cnt_q <= '0;
    end else if (count_inc) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubbleCount = bubble_cnt_q;
`else
  logic unused_count_inc;
  assign unused_count_inc = count_inc;
  assign bubbleCount      = '0;
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed and random checks of id_exe_stage against a cycle-level reference model.
module tb_id_exe_stage;

  localparam int unsigned N = 32;
`ifdef ID_EXE_PERF_COUNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          valid_ID = 1'b0;
  logic [4:0]    rs_id = '0, rt_id = '0, wa_id = '0;
  logic [N-1:0]  a_id = '0, b_id = '0;
  logic [3:0]    ctrl_id = '0;
  logic [5:0]    op_id = '0;
  logic          flush = 1'b0, hold = 1'b0;

  logic          valid_x;
  logic [4:0]    rs_x, rt_x, wa_x;
  logic [N-1:0]  a_x, b_x;
  logic [3:0]    ctrl_x;
  logic [5:0]    op_x;
  logic          stall;
  logic [31:0]   bubbleCount;

  int total = 0;
  int bad   = 0;

  // Reference model of the EXE-side register contents and bubble count
  logic          m_valid;
  logic [4:0]    m_rs, m_rt, m_wa;
  logic [N-1:0]  m_a, m_b;
  logic [3:0]    m_ctrl;
  logic [5:0]    m_op;
  logic [31:0]   m_cnt;

  id_exe_stage #(.N(N)) dut (
    .CLK                     (CLK),
    .RST                     (RST),
    .valid_ID                (valid_ID),
    .regReadAddress1_ID      (rs_id),
    .regReadAddress2_ID      (rt_id),
    .regReadData1_ID         (a_id),
    .operandB_ID             (b_id),
    .regWriteAddress_ID      (wa_id),
    .ctrl_ID                 (ctrl_id),
    .aluOpCode_ID            (op_id),
    .flush                   (flush),
    .hold                    (hold),
    .valid_IDtoEXE           (valid_x),
    .regReadAddress1_IDtoEXE (rs_x),
    .regReadAddress2_IDtoEXE (rt_x),
    .inputA_reg              (a_x),
    .inputB_IDtoEXE          (b_x),
    .regWriteAddress_IDtoEXE (wa_x),
    .ctrl_IDtoEXE            (ctrl_x),
    .aluOpCode_IDtoEXE       (op_x),
    .stall                   (stall),
    .bubbleCount             (bubbleCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_rs = '0; m_rt = '0; m_wa = '0;
    m_a = '0; m_b = '0; m_ctrl = '0; m_op = 6'b000000;
  endtask

  // A load-use hazard: EXE holds a real load to a nonzero register that ID reads.
  function automatic logic model_hazard();
    logic reads_rt;
    reads_rt = ctrl_id[2] | ctrl_id[0];
    return m_valid && m_ctrl[1] && m_ctrl[3] && (m_wa != 0) && valid_ID &&
           ((m_wa == rs_id) || (reads_rt && (m_wa == rt_id)));
  endfunction

  function automatic logic model_stall();
    if (flush) return 1'b0;
    if (hold)  return 1'b1;
    return model_hazard();
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_valid"}, {31'b0, valid_x}, {31'b0, m_valid});
    chk({tag, "_rs"},    {27'b0, rs_x},    {27'b0, m_rs});
    chk({tag, "_rt"},    {27'b0, rt_x},    {27'b0, m_rt});
    chk({tag, "_a"},     a_x,              m_a);
    chk({tag, "_b"},     b_x,              m_b);
    chk({tag, "_wa"},    {27'b0, wa_x},    {27'b0, m_wa});
    chk({tag, "_ctrl"},  {28'b0, ctrl_x},  {28'b0, m_ctrl});
    chk({tag, "_op"},    {26'b0, op_x},    {26'b0, m_op});
    chk({tag, "_cnt"},   bubbleCount,      m_cnt);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa,
                       input logic [3:0] c, input logic [5:0] op, input logic fl,
                       input logic hd);
    @(negedge CLK);
    valid_ID = v; rs_id = rs; rt_id = rt; a_id = a; b_id = b; wa_id = wa;
    ctrl_id = c; op_id = op; flush = fl; hold = hd;
  endtask

  // Check stall before the edge, advance the model across the edge, then check registers.
  task automatic step(input string tag);
    logic haz;
    #1;
    haz = model_hazard();
    chk({tag, "_stall"}, {31'b0, stall}, {31'b0, model_stall()});
    @(posedge CLK);
    if (flush || (!hold && haz)) begin
      model_clear();
      if (PerfEn) m_cnt = m_cnt + 32'd1;
    end else if (!hold) begin
      m_valid = valid_ID; m_rs = rs_id; m_rt = rt_id; m_wa = wa_id;
      m_a = a_id; m_b = b_id; m_ctrl = ctrl_id; m_op = op_id;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    model_clear();
    m_cnt = '0;

    // Reset state
    #3;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    check_regs("reset");
    @(negedge CLK);
    RST = 1'b0;

    // lw $2 then add $3,$2,$4: one stall cycle, one bubble, add enters next edge
    drive(1, 5'd1, 5'd0, 32'd100, 32'd4, 5'd2, 4'b1010, 6'b100000, 0, 0);
    step("lw1");
    drive(1, 5'd2, 5'd4, 32'h11, 32'h22, 5'd3, 4'b1100, 6'b100000, 0, 0);
    #1 chk("lu_add_stall", {31'b0, stall}, 32'd1);
    step("lu_add_bub");
    chk("lu_add_bub_valid", {31'b0, valid_x}, 32'd0);
    chk("lu_add_bub_cnt", bubbleCount, PerfEn ? 32'd1 : 32'd0);
    step("lu_add_go");
    chk("lu_add_go_wa", {27'b0, wa_x}, 32'd3);

    // lw $2 then addi $5,$2,8 (rs match only)
    drive(1, 5'd1, 5'd0, 32'd200, 32'd8, 5'd2, 4'b1010, 6'b100000, 0, 0);
    step("lw2");
    drive(1, 5'd2, 5'd5, 32'h33, 32'd8, 5'd5, 4'b1000, 6'b100000, 0, 0);
    #1 chk("lu_addi_stall", {31'b0, stall}, 32'd1);
    step("lu_addi");
    // lw $2 then sw with rt=2
    drive(1, 5'd1, 5'd0, 32'd300, 32'd8, 5'd2, 4'b1010, 6'b100000, 0, 0);
    step("lw3");
    drive(1, 5'd3, 5'd2, 32'h44, 32'd12, 5'd0, 4'b0001, 6'b100000, 0, 0);
    #1 chk("lu_sw_stall", {31'b0, stall}, 32'd1);
    step("lu_sw");
    // lw $0 then add with rs=0: no hazard
    drive(1, 5'd1, 5'd0, 32'd400, 32'd8, 5'd0, 4'b1010, 6'b100000, 0, 0);
    step("lw0");
    drive(1, 5'd0, 5'd0, 32'h55, 32'h66, 5'd7, 4'b1100, 6'b100000, 0, 0);
    #1 chk("lu_zero_stall", {31'b0, stall}, 32'd0);
    step("lu_zero");

    // flush together with a hazard
    drive(1, 5'd1, 5'd0, 32'd500, 32'd8, 5'd2, 4'b1010, 6'b100000, 0, 0);
    step("lw4");
    drive(1, 5'd2, 5'd4, 32'h77, 32'h88, 5'd3, 4'b1100, 6'b100000, 1, 1);
    #1 chk("flush_stall", {31'b0, stall}, 32'd0);
    step("flush");
    chk("flush_valid", {31'b0, valid_x}, 32'd0);

    // hold for 3 cycles, then resume with the held instruction
    drive(1, 5'd6, 5'd7, 32'h0000_00AA, 32'h5, 5'd9, 4'b1100, 6'b100101, 0, 0);
    step("pre_hold");
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd10, 5'd11, 32'hBB, 32'hCC, 5'd12, 4'b1100, 6'b100010, 0, 1);
      #1 chk("hold_stall", {31'b0, stall}, 32'd1);
      step("hold");
      chk("hold_a", a_x, 32'h0000_00AA);
    end
    drive(1, 5'd10, 5'd11, 32'hBB, 32'hCC, 5'd12, 4'b1100, 6'b100010, 0, 0);
    step("resume");
    chk("resume_a", a_x, 32'hBB);

    // reset pulsed while stalled
    drive(1, 5'd1, 5'd0, 32'd600, 32'd8, 5'd2, 4'b1010, 6'b100000, 0, 0);
    step("lw5");
    drive(1, 5'd2, 5'd4, 32'h99, 32'hAB, 5'd3, 4'b1100, 6'b100000, 0, 0);
    #1 chk("rst_pre_stall", {31'b0, stall}, 32'd1);
    RST = 1'b1;
    #1;
    model_clear();
    m_cnt = '0;
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    check_regs("rst_mid");
    @(negedge CLK);
    RST = 1'b0;
    step("after_rst");
    chk("after_rst_valid", {31'b0, valid_x}, 32'd1);

`ifdef ID_EXE_PERF_COUNT_EN
    // counter wrap from all-ones
    @(negedge CLK);
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.bubble_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    drive(1, 5'd1, 5'd1, 32'd1, 32'd1, 5'd1, 4'b1100, 6'b100000, 1, 0);
    step("wrap");
    chk("wrap_cnt", bubbleCount, 32'd0);
`endif

    // random traffic on a small register window so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, $urandom, 5'($urandom_range(0, 3)), 4'($urandom), 6'($urandom),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
